// File: rtl/instr_enc.sv
// RV32I instruction encoder and program streamer: packs decoded fields into a
// 32-bit word, range-checks the immediate and streams words with byte addresses.
module instr_enc #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              err_sticky,
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A signed range [-2^n, 2^n-1] holds exactly when imm[31:n] is all zeros or all ones.
  function automatic logic bundle_legal(input logic [2:0] f, input logic [6:0] op,
                                        input logic [31:0] im);
    logic ok;
    ok = (op[1:0] == 2'b11);
    case (f)
      FMT_R:        ok = ok;
      FMT_I, FMT_S: ok = ok && ((&im[31:11]) || !(|im[31:11]));
      FMT_B:        ok = ok && ((&im[31:12]) || !(|im[31:12])) && !im[0];
      FMT_U:        ok = ok && (im[11:0] == 12'd0);
      FMT_J:        ok = ok && ((&im[31:20]) || !(|im[31:20])) && !im[0];
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] f, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [31:0] im);
    logic [31:0] w;
    case (f)
      FMT_R:   w = {f7, s2, s1, f3, d, op};
      FMT_I:   w = {im[11:0], s1, f3, d, op};
      FMT_S:   w = {im[11:5], s2, s1, f3, im[4:0], op};
      FMT_B:   w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      FMT_U:   w = {im[31:12], d, op};
      FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], d, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                out_valid_r, out_valid_s;
  logic [31:0]         out_instr_r, out_instr_s;
  logic [ADDR_W-1:0]   out_addr_r, out_addr_s;
  logic                err_r, err_s;
  logic                err_sticky_r, err_sticky_s;
  logic                done_r, done_s;

  logic                in_ready_s;
  logic                accept_s;
  logic                legal_s;
  logic [31:0]         encoded_s;

  assign in_ready_s = (state_r == S_RUN) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign legal_s    = bundle_legal(fmt, opcode, imm);
  assign encoded_s  = encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);

  // Next-state, address/count and output-register update.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    count_s      = count_r;
    out_instr_s  = out_instr_r;
    out_addr_s   = out_addr_r;
    err_s        = 1'b0;
    err_sticky_s = err_sticky_r;
    if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s      = S_RUN;
          addr_s       = {base_addr[ADDR_W-1:2], 2'b00};
          count_s      = CNT_ZERO;
          err_sticky_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          if (legal_s) begin
            out_valid_s = 1'b1;
            out_instr_s = encoded_s;
            out_addr_s  = addr_r;
            addr_s      = addr_r + ADDR_STEP;
            count_s     = count_r + CNT_ONE;
          end else begin
            err_s        = 1'b1;
            err_sticky_s = 1'b1;
          end
          // A rejected final bundle still closes the program.
          if (in_last || (legal_s && (count_r == CNT_LAST))) begin
            state_s = S_DRAIN;
          end else begin
            state_s = S_RUN;
          end
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_r || out_ready) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase
    done_s = (state_s == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      count_r      <= CNT_ZERO;
      out_valid_r  <= 1'b0;
      out_instr_r  <= 32'd0;
      out_addr_r   <= {ADDR_W{1'b0}};
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      count_r      <= count_s;
      out_valid_r  <= out_valid_s;
      out_instr_r  <= out_instr_s;
      out_addr_r   <= out_addr_s;
      err_r        <= err_s;
      err_sticky_r <= err_sticky_s;
      done_r       <= done_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_instr  = out_instr_r;
  assign out_addr   = out_addr_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;
  assign done       = done_r;

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: vector table plus scoreboard of expected
// {address, word} pairs, with hand sequences for stalls, DEPTH limit and reset.
module tb_instr_enc;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_last, out_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [2:0]        fmt, funct3;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic              in_ready, out_valid, err, err_sticky, done;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  instr_enc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_sticky(err_sticky), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        last;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  int                n_vec = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                hs_count = 0;
  int                hs_cyc [0:63];
  logic [43:0]       sb_q [$];
  logic [ADDR_W-1:0] model_addr;
  vec_t              tbl [0:8];
  vec_t              v;

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im, input logic l,
                              input logic lg, input logic [31:0] w);
    vec_t r;
    r.fmt = f; r.opcode = op; r.funct3 = f3; r.funct7 = f7;
    r.rd = d; r.rs1 = s1; r.rs2 = s2; r.imm = im;
    r.last = l; r.legal = lg; r.instr = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    fmt = x.fmt; opcode = x.opcode; funct3 = x.funct3; funct7 = x.funct7;
    rd = x.rd; rs1 = x.rs1; rs2 = x.rs2; imm = x.imm; in_last = x.last;
    in_valid = 1'b1;
  endtask

  // Entered and left at a falling edge; back-to-back calls give one accept per cycle.
  task automatic send(input vec_t x);
    int n;
    drive(x);
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    if (x.legal) begin
      sb_q.push_back({model_addr, x.instr});
      model_addr = model_addr + 12'd4;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("err_pulse", {31'd0, err}, {31'd0, !x.legal});
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1;
    base_addr = b;
    model_addr = {b[ADDR_W-1:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", {20'd0, out_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every handshaked word against the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (hs_count < 64) hs_cyc[hs_count] = cyc;
      hs_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_word", out_instr, 32'hFFFF_FFFF);
      end else begin
        logic [43:0] e;
        e = sb_q.pop_front();
        check("out_instr", out_instr, e[31:0]);
        check("out_addr", {20'd0, out_addr}, {20'd0, e[43:32]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0;
    tbl[0] = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0050_0093);
    tbl[1] = mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020_81B3);
    tbl[2] = mk(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020_A423);
    tbl[3] = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0);
    tbl[4] = mk(3'd0, 7'h12, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 32'd0);
    tbl[5] = mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 1'b0, 32'd0);
    tbl[6] = mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 1'b0, 32'd0);
    tbl[7] = mk(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tbl[8] = mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 1'b1, 32'hFE20_8CE3);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    base_addr = '0; fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0; model_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Program 1: table, one-cycle latency, no bubble between R and S.
    do_start(12'h100);
    for (int i = 0; i < 9; i++) begin
      send(tbl[i]);
      if (i == 0) check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    end
    wait_done();
    check("no_bubble", hs_cyc[2] - hs_cyc[1], 32'd1);
    check("sticky_after_prog1", {31'd0, err_sticky}, 32'd1);

    // Program 2: U, rejected B, J at unchanged address, then output stall.
    do_start(12'h200);
    check("sticky_cleared_by_start", {31'd0, err_sticky}, 32'd0);
    send(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_52B7));
    send(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 1'b0, 32'd0));
    check("err_sticky_set", {31'd0, err_sticky}, 32'd1);
    check("no_word_on_reject", {31'd0, out_valid}, 32'd0);
    send(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b1, 32'h0100_00EF));
    out_ready = 1'b0;
    v = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFF0_0113);
    drive(v);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_instr", out_instr, 32'h0100_00EF);
      check("stall_addr", {20'd0, out_addr}, 32'h0000_0204);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.push_back({model_addr, v.instr});
    model_addr = model_addr + 12'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("release_next_valid", {31'd0, out_valid}, 32'd1);
    check("release_next_addr", {20'd0, out_addr}, 32'h0000_0208);
    wait_done();

    // Program 3: DEPTH limit with no in_last, address wraps past 0xFFC.
    hs0 = hs_count;
    do_start(12'hFFE);
    for (int k = 1; k <= 4; k++)
      send(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0, 1'b1,
              (32'(k) << 20) | 32'h0000_0093));
    wait_done();
    check("depth_word_count", hs_count - hs0, 32'd4);

    // Program 4: reset mid-program with a word pending.
    do_start(12'h040);
    send(mk(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0));
    check("sticky_before_rst", {31'd0, err_sticky}, 32'd1);
    out_ready = 1'b0;
    send(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1, 32'h0070_0093));
    check("pending_before_rst", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb_q.delete();
    check_reset_outputs();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Program 5: immediate range extremes that remain legal.
    do_start(12'h500);
    send(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b0, 1'b1, 32'h8000_0093));
    send(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd1048574, 1'b1, 1'b1, 32'h7FFF_F06F));
    wait_done();
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
